// File: rtl/dem_tran_sel.sv
// -----------------------------------------------------------------------------
// dem_tran_sel
//   Unit-element selector for the source side of the DAC_Digital transition
//   detectors. A thermometer count (0..N_ELEM) becomes an N_ELEM-bit
//   element-select vector SV. Elements that are already on stay on where
//   possible. Elements to add are picked by a rotating on-pointer. Elements to
//   drop are picked by a separate rotating off-pointer. This spreads switching
//   activity evenly across the elements. The block also registers the
//   rising-transition vector ST (~SV_old & SV_new) and keeps one saturating
//   rising-transition counter per element.
//
// Ports
//   clk       in   1       clock
//   rst       in   1       asynchronous active-high reset
//   clk_en    in   1       update strobe; code is sampled only when 1
//   code      in   CODE_W  requested number of active elements
//   cnt_clr   in   1       synchronous clear of all transition counters
//   cnt_sel   in   CODE_W  counter read index
//   SV        out  N_ELEM  registered element-select vector
//   ST        out  N_ELEM  registered rising-transition vector (1-cycle pulse)
//   cnt_rd    out  CNT_W   counter[cnt_sel], or 0 when cnt_sel >= N_ELEM
//   code_err  out  1       sticky: a code > N_ELEM was sampled
// -----------------------------------------------------------------------------
module dem_tran_sel #(
  parameter int N_ELEM = 6,
  parameter int CODE_W = 3,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic [CODE_W-1:0] code,
  input  logic              cnt_clr,
  input  logic [CODE_W-1:0] cnt_sel,
  output logic [N_ELEM-1:0] SV,
  output logic [N_ELEM-1:0] ST,
  output logic [CNT_W-1:0]  cnt_rd,
  output logic              code_err
);

  localparam int                IDX_W    = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
  localparam logic [CODE_W-1:0] N_CODE   = CODE_W'(N_ELEM);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_ELEM - 1);

  logic [IDX_W-1:0]  on_ptr, off_ptr;
  logic [IDX_W-1:0]  on_ptr_nxt, off_ptr_nxt;
  logic [N_ELEM-1:0] sv_nxt, st_nxt;
  logic [CODE_W-1:0] k, n;
  logic [CNT_W-1:0]  cnt [N_ELEM];

  // Clamp the request to the number of physical elements.
  assign k = (code > N_CODE) ? N_CODE : code;

  // Number of elements currently on. It always fits in CODE_W bits
  // because 2**CODE_W > N_ELEM.
  always_comb begin
    n = '0;
    for (int i = 0; i < N_ELEM; i++) n = n + CODE_W'(SV[i]);
  end

  // Single-pass circular scan. It starts at the relevant pointer and flips
  // the first |k-n| candidates. Each pointer lands just past the last
  // element it flipped.
  always_comb begin : select
    logic [CODE_W-1:0] need;
    logic [IDX_W-1:0]  p;
    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred. Blocking '=' is correct
    // here because later loop iterations must see the updated need and p.
    sv_nxt      = SV;
    on_ptr_nxt  = on_ptr;
    off_ptr_nxt = off_ptr;
    need        = '0;
    p           = '0;
    if (k > n) begin
      need = k - n;
      p    = on_ptr;
      for (int j = 0; j < N_ELEM; j++) begin
        if (need != '0 && !SV[p]) begin
          sv_nxt[p]  = 1'b1;
          need       = need - CODE_W'(1);
          on_ptr_nxt = (p == LAST_IDX) ? '0 : p + IDX_W'(1);
        end
        p = (p == LAST_IDX) ? '0 : p + IDX_W'(1);
      end
    end else if (k < n) begin
      need = n - k;
      p    = off_ptr;
      for (int j = 0; j < N_ELEM; j++) begin
        if (need != '0 && SV[p]) begin
          sv_nxt[p]   = 1'b0;
          need        = need - CODE_W'(1);
          off_ptr_nxt = (p == LAST_IDX) ? '0 : p + IDX_W'(1);
        end
        p = (p == LAST_IDX) ? '0 : p + IDX_W'(1);
      end
    end
  end

  assign st_nxt = ~SV & sv_nxt;

  // NOTE: registered state uses non-blocking '<=' so that every flop samples
  // pre-edge values, whatever order the blocks are evaluated in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      SV       <= '0;
      ST       <= '0;
      on_ptr   <= '0;
      off_ptr  <= '0;
      code_err <= 1'b0;
    end else begin
      ST <= '0;
      if (clk_en) begin
        SV      <= sv_nxt;
        ST      <= st_nxt;
        on_ptr  <= on_ptr_nxt;
        off_ptr <= off_ptr_nxt;
        if (code > N_CODE) code_err <= 1'b1;
      end
    end
  end

  // Per-element saturating rising-transition counters. A clear takes
  // precedence over a same-edge increment.
  // NOTE: the counter array is reset explicitly because its contents are
  // architecturally visible through cnt_rd. A plain data memory would not
  // need a reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_ELEM; i++) cnt[i] <= '0;
    end else if (cnt_clr) begin
      for (int i = 0; i < N_ELEM; i++) cnt[i] <= '0;
    end else if (clk_en) begin
      for (int i = 0; i < N_ELEM; i++)
        if (st_nxt[i] && cnt[i] != '1) cnt[i] <= cnt[i] + CNT_W'(1);
    end
  end

  always_comb begin
    cnt_rd = '0;
    if (cnt_sel < N_CODE) cnt_rd = cnt[cnt_sel[IDX_W-1:0]];
  end

endmodule

// File: tb/tb_dem_tran_sel.sv
// -----------------------------------------------------------------------------
// tb_dem_tran_sel
//   Self-checking bench for dem_tran_sel (N_ELEM=6, CODE_W=3, CNT_W=8).
//   A table of update vectors carries hand-derived SV/ST/code_err
//   expectations. Each expectation is queued when its stimulus is driven and
//   popped for comparison after the update edge. Hand-written sequences cover
//   counter values, saturation, clear-vs-increment priority, out-of-range
//   counter reads, and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_dem_tran_sel;

  typedef struct {
    logic       en;
    logic [2:0] code;
    logic       clr;
    logic [5:0] sv;
    logic [5:0] st;
    logic       err;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       clk_en;
  logic [2:0] code;
  logic       cnt_clr;
  logic [2:0] cnt_sel;
  logic [5:0] SV, ST;
  logic [7:0] cnt_rd;
  logic       code_err;

  int total = 0;
  int bad   = 0;

  vec_t exp_q[$];
  vec_t tbl[14];

  dem_tran_sel #(.N_ELEM(6), .CODE_W(3), .CNT_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .clk_en   (clk_en),
    .code     (code),
    .cnt_clr  (cnt_clr),
    .cnt_sel  (cnt_sel),
    .SV       (SV),
    .ST       (ST),
    .cnt_rd   (cnt_rd),
    .code_err (code_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: time limit reached before the test completed");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one update at the falling edge. Queue its expectation, then compare
  // just after the rising edge.
  task automatic apply(input vec_t v);
    vec_t e;
    @(negedge clk);
    clk_en  = v.en;
    code    = v.code;
    cnt_clr = v.clr;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check($sformatf("SV code=%0d en=%0b", e.code, e.en), 32'(SV), 32'(e.sv));
    check($sformatf("ST code=%0d en=%0b", e.code, e.en), 32'(ST), 32'(e.st));
    check($sformatf("err code=%0d", e.code), 32'(code_err), 32'(e.err));
  endtask

  task automatic drive(input logic en, input logic [2:0] c, input logic clr);
    @(negedge clk);
    clk_en  = en;
    code    = c;
    cnt_clr = clr;
  endtask

  task automatic check_cnt(input logic [2:0] sel, input logic [7:0] exp);
    @(negedge clk);
    clk_en  = 1'b0;
    cnt_clr = 1'b0;
    cnt_sel = sel;
    #1;
    check($sformatf("cnt_rd[%0d]", sel), 32'(cnt_rd), 32'(exp));
  endtask

  initial begin
    logic [7:0] exp_cnt [6];

    tbl[0]  = '{1'b1, 3'd3, 1'b0, 6'b000111, 6'b000111, 1'b0};
    tbl[1]  = '{1'b1, 3'd3, 1'b0, 6'b000111, 6'b000000, 1'b0};
    tbl[2]  = '{1'b1, 3'd5, 1'b0, 6'b011111, 6'b011000, 1'b0};
    tbl[3]  = '{1'b1, 3'd6, 1'b0, 6'b111111, 6'b100000, 1'b0};  // on_ptr wraps to 0
    tbl[4]  = '{1'b1, 3'd4, 1'b0, 6'b111100, 6'b000000, 1'b0};  // off_ptr -> 2
    tbl[5]  = '{1'b1, 3'd5, 1'b0, 6'b111101, 6'b000001, 1'b0};  // on_ptr -> 1
    tbl[6]  = '{1'b0, 3'd0, 1'b0, 6'b111101, 6'b000000, 1'b0};  // clk_en low: hold
    tbl[7]  = '{1'b1, 3'd7, 1'b0, 6'b111111, 6'b000010, 1'b1};  // clamped, on_ptr -> 2
    tbl[8]  = '{1'b1, 3'd2, 1'b0, 6'b000011, 6'b000000, 1'b1};  // drop 2..5, off_ptr -> 0
    tbl[9]  = '{1'b1, 3'd0, 1'b0, 6'b000000, 6'b000000, 1'b1};  // off_ptr -> 2
    tbl[10] = '{1'b1, 3'd1, 1'b0, 6'b000100, 6'b000100, 1'b1};  // on_ptr -> 3
    tbl[11] = '{1'b1, 3'd3, 1'b0, 6'b011100, 6'b011000, 1'b1};  // on_ptr -> 5
    tbl[12] = '{1'b1, 3'd2, 1'b0, 6'b011000, 6'b000000, 1'b1};  // off_ptr -> 3
    tbl[13] = '{1'b1, 3'd4, 1'b0, 6'b111001, 6'b100001, 1'b1};  // wrap 5 -> 0

    // Rising transitions per element accumulated over the table.
    exp_cnt = '{8'd3, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2};

    rst = 1'b1; clk_en = 1'b0; code = '0; cnt_clr = 1'b0; cnt_sel = '0;
    #12;
    check("reset SV", 32'(SV), 32'h0);
    check("reset err", 32'(code_err), 32'h0);
    check("reset cnt_rd", 32'(cnt_rd), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) apply(tbl[i]);

    for (int i = 0; i < 6; i++) check_cnt(3'(i), exp_cnt[i]);
    check_cnt(3'd6, 8'd0);
    check_cnt(3'd7, 8'd0);

    // Asynchronous reset between clock edges.
    cnt_sel = 3'd0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async rst SV", 32'(SV), 32'h0);
    check("async rst ST", 32'(ST), 32'h0);
    check("async rst cnt_rd", 32'(cnt_rd), 32'h0);
    check("async rst err", 32'(code_err), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Saturation: each 6/0 pair raises every element once; 300 > 255.
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 3'd6, 1'b0);
      drive(1'b1, 3'd0, 1'b0);
    end
    for (int i = 0; i < 6; i++) check_cnt(3'(i), 8'd255);
    check_cnt(3'd6, 8'd0);

    // A clear on the same edge as a rising update discards that increment.
    apply('{1'b1, 3'd6, 1'b1, 6'b111111, 6'b111111, 1'b0});
    for (int i = 0; i < 6; i++) check_cnt(3'(i), 8'd0);

    // Counting resumes from zero after the clear.
    drive(1'b1, 3'd0, 1'b0);
    drive(1'b1, 3'd6, 1'b0);
    for (int i = 0; i < 6; i++) check_cnt(3'(i), 8'd1);

    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard: %0d expectations left unpopped", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
